vid_timing_pattern_gen: RTL

Generates progressive video raster timing and an RGB888 test pattern on the pixel clock. Outputs vid_pdata/vid_pvde/vid_phsync/vid_pvsync directly feed the TMDS transmitter stage (rgb888 in, serialized DVI out). Used for bring-up of the DVI/HDMI output path without a frame buffer.

---
 rtl/vid_timing_pattern_gen.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vid_timing_pattern_gen.sv
// Progressive raster timing generator with RGB888 test patterns (bars, solid, grey ramp, checker).
// Optional white edge overlay when VTG_BORDER_EN is defined.
module vid_timing_pattern_gen #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        pixelclk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    output logic [23:0] vid_pdata,
    output logic        vid_pvde,
    output logic        vid_phsync,
    output logic        vid_pvsync,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BW      = H_ACTIVE / 8;
    localparam int BPW     = (BW > 1) ? $clog2(BW) : 1;

    localparam logic [HW-1:0]  H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0]  H_RIGHT   = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0]  HS_BEG    = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]  HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0]  H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]  V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0]  V_BOTTOM  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0]  VS_BEG    = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]  VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0]  V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [BPW-1:0] BAR_LAST  = BPW'(BW - 1);

    logic [HW-1:0]  h_cnt_reg, h_cnt_next;
    logic [VW-1:0]  v_cnt_reg, v_cnt_next;
    logic [2:0]     bar_idx_reg, bar_idx_next;
    logic [BPW-1:0] bar_px_reg, bar_px_next;
    logic [1:0]     pat_sel_reg;
    logic [23:0]    solid_reg;

    logic        frame_origin;
    logic        de_next;
    logic        hs_active, vs_active;
    logic [1:0]  cur_sel;
    logic [23:0] cur_solid;
    logic [23:0] pix_next;
    logic [15:0] x_ext, y_ext;

    assign frame_origin = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    assign de_next      = (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
    assign hs_active    = (h_cnt_reg >= HS_BEG) && (h_cnt_reg < HS_END);
    assign vs_active    = (v_cnt_reg >= VS_BEG) && (v_cnt_reg < VS_END);
    assign x_ext        = 16'(h_cnt_reg);
    assign y_ext        = 16'(v_cnt_reg);

    // Raster counters plus a per-line bar tracker that replaces x / BW.
    always_comb begin
        h_cnt_next   = h_cnt_reg;
        v_cnt_next   = v_cnt_reg;
        bar_idx_next = bar_idx_reg;
        bar_px_next  = bar_px_reg;
        if (!enable) begin
            h_cnt_next   = '0;
            v_cnt_next   = '0;
            bar_idx_next = '0;
            bar_px_next  = '0;
        end else if (h_cnt_reg == H_LAST) begin
            h_cnt_next   = '0;
            v_cnt_next   = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
            bar_idx_next = '0;
            bar_px_next  = '0;
        end else begin
            h_cnt_next = h_cnt_reg + 1'b1;
            if (bar_idx_reg != 3'd7) begin
                if (bar_px_reg == BAR_LAST) begin
                    bar_idx_next = bar_idx_reg + 1'b1;
                    bar_px_next  = '0;
                end else begin
                    bar_px_next = bar_px_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge pixelclk) begin
        if (rst) begin
            h_cnt_reg   <= '0;
            v_cnt_reg   <= '0;
            bar_idx_reg <= '0;
            bar_px_reg  <= '0;
        end else begin
            h_cnt_reg   <= h_cnt_next;
            v_cnt_reg   <= v_cnt_next;
            bar_idx_reg <= bar_idx_next;
            bar_px_reg  <= bar_px_next;
        end
    end

    // Pattern selection is sampled at the frame origin so the origin pixel already uses it.
    always_ff @(posedge pixelclk) begin
        if (rst) begin
            pat_sel_reg <= '0;
            solid_reg   <= '0;
        end else if (enable && frame_origin) begin
            pat_sel_reg <= pattern_sel;
            solid_reg   <= solid_rgb;
        end
    end

    assign cur_sel   = frame_origin ? pattern_sel : pat_sel_reg;
    assign cur_solid = frame_origin ? solid_rgb   : solid_reg;

    always_comb begin
        pix_next = '0;
        case (cur_sel)
            2'd0:    pix_next = {{8{~bar_idx_reg[1]}}, {8{~bar_idx_reg[2]}}, {8{~bar_idx_reg[0]}}};
            2'd1:    pix_next = cur_solid;
            2'd2:    pix_next = {3{x_ext[7:0]}};
            default: pix_next = (x_ext[5] ^ y_ext[5]) ? 24'hFFFFFF : 24'h000000;
        endcase
`ifdef VTG_BORDER_EN
        if ((h_cnt_reg == '0) || (h_cnt_reg == H_RIGHT) ||
            (v_cnt_reg == '0) || (v_cnt_reg == V_BOTTOM))
            pix_next = 24'hFFFFFF;
`endif
    end

    always_ff @(posedge pixelclk) begin
        if (rst || !enable) begin
            vid_pdata   <= '0;
            vid_pvde    <= 1'b0;
            vid_phsync  <= ~HS_POL;
            vid_pvsync  <= ~VS_POL;
            frame_start <= 1'b0;
        end else begin
            vid_pdata   <= de_next ? pix_next : 24'h000000;
            vid_pvde    <= de_next;
            vid_phsync  <= hs_active ? HS_POL : ~HS_POL;
            vid_pvsync  <= vs_active ? VS_POL : ~VS_POL;
            frame_start <= frame_origin;
        end
    end

endmodule
